pipeline_hazard_sequencer: RTL and testbench
============================================

Name: pipeline_hazard_sequencer

Overview:
Central stall/flush sequencer for the 5-stage pipelined MIPS core. It consumes the decoded control bits (MemRead, MemWrite, Branch, Jump, Jr) carried down the pipeline, plus register indices and data-memory handshake. It drives PC and pipeline-register write enables, bubble inserts and flushes. It handles load-use hazards, taken branch/jump redirects and variable-latency data memory, with timeout detection.

Parameters:
MEM_TIMEOUT, 15, max MEM_WAIT cycles before mem_error (1..255)
CNT_W, 16, width of performance counters

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs of instruction in ID
id_rt  in  5  rt of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  MemRead of instruction in EX
ex_rt  in  5  destination rt of load in EX
ex_branch_taken  in  1  branch in EX resolved taken (Branch 01/11 evaluated)
id_jump  in  1  Jump or Jr decoded in ID
mem_req  in  1  MEM stage holds MemRead or MemWrite
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID cleared to NOP on next edge
id_ex_bubble  out  1  ID/EX control cleared (bubble) on next edge
ex_mem_write  out  1  EX/MEM write enable
mem_wb_bubble  out  1  MEM/WB control cleared on next edge
redirect  out  1  PC takes branch/jump target this cycle
mem_error  out  1  sticky timeout flag
stall_cycles  out  CNT_W  freeze + load-use stall cycles
flush_count  out  CNT_W  applied flush events

Behaviour:
- Reset (async): state=RUN, wait_cnt=0, pend_flush=0, mem_error=0, counters=0. Outputs at reset: pc_write=1, if_id_write=1, ex_mem_write=1, all flush/bubble/redirect=0.
- States: RUN, MEM_WAIT. 2-bit state register.
- freeze = mem_req & ~mem_ready (any state). Zero-wait access (mem_ready same cycle as mem_req) causes no stall.
- freeze=1: pc_write=0, if_id_write=0, ex_mem_write=0, id_ex_bubble=0, if_id_flush=0, redirect=0, mem_wb_bubble=1.
- RUN->MEM_WAIT on freeze. MEM_WAIT->RUN on the edge after mem_ready=1. Pipeline advances in the mem_ready cycle.
- wait_cnt: cleared in RUN, incremented each MEM_WAIT cycle, saturates. When wait_cnt reaches MEM_TIMEOUT: set mem_error (sticky until Reset), return to RUN, treat access as complete (unfreeze one cycle).
- Priority when not frozen: (1) taken branch or pending flush, (2) jump, (3) load-use.
- Branch: ex_branch_taken or pend_flush -> redirect=1, if_id_flush=1, id_ex_bubble=1, pc_write=1. Clears pend_flush.
- ex_branch_taken during freeze -> pend_flush=1. Redirect target is held by the datapath; the flush is applied in the first unfrozen cycle.
- Jump: id_jump -> redirect=1, if_id_flush=1, pc_write=1. No ID/EX bubble. Ignored if a branch flush fires the same cycle.
- Load-use: ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)). Response: pc_write=0, if_id_write=0, id_ex_bubble=1. Exactly one cycle, since the load advances to MEM. Suppressed by branch flush.
- Counters: stall_cycles increments on freeze or load-use cycles. flush_count increments per applied branch or jump flush. Both wrap modulo 2^CNT_W.

Optional Feature:
PERF_COUNTERS_EN. Defined: stall_cycles and flush_count are implemented as above. Undefined: both ports tied to 0, no counter flops.

Test Plan:
- lw $t0 in EX (ex_rt=8), ID reads rs=8 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; the next cycle is normal; stall_cycles=1.
- Load-use with ex_rt=0 -> no stall.
- mem_req=1, mem_ready low for 3 cycles then high -> 3 freeze cycles with mem_wb_bubble=1, state MEM_WAIT, advance on the 4th cycle; stall_cycles=3.
- ex_branch_taken during cycle 2 of a 4-cycle freeze -> no redirect while frozen; redirect=1, if_id_flush=1, id_ex_bubble=1 in the first unfrozen cycle; flush_count=1.
- ex_branch_taken + id_jump + load-use in the same unfrozen cycle -> branch flush only; pc_write=1, flush_count +1.
- mem_ready never asserted with MEM_TIMEOUT=15 -> mem_error=1 after 15 MEM_WAIT cycles, return to RUN, sticky until Reset; Reset mid-MEM_WAIT -> RUN, outputs at reset values immediately.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Resolves
// data-memory freezes, taken-branch/jump redirects and load-use stalls,
// and flags data-memory timeouts.
//
// Optional feature macro: PERF_COUNTERS_EN (defined -> stall/flush counters
// implemented; undefined -> counter ports tied to zero, no counter flops).
//
// Ports:
//   CLK, Reset              clock (rising edge), async active-high reset
//   id_rs/id_rt, id_uses_*  source registers read by the ID instruction
//   ex_mem_read, ex_rt      load in EX and its destination register
//   ex_branch_taken         branch in EX resolved taken
//   id_jump                 J/JAL/JR decoded in ID
//   mem_req, mem_ready      data-memory access in MEM and its completion
//   pc_write, if_id_write, ex_mem_write    stage write enables
//   if_id_flush, id_ex_bubble, mem_wb_bubble  NOP/bubble inserts
//   redirect                PC takes branch/jump target this cycle
//   mem_error               sticky data-memory timeout flag
//   stall_cycles, flush_count  performance counters
module pipeline_hazard_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             redirect,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned         WAIT_W    = 8;
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]   WAIT_MAX  = {WAIT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_pend_flush, w_pend_flush_nxt;
  logic              r_mem_error, w_mem_error_nxt;
  logic              r_force_go, w_force_go_nxt;
  logic              w_freeze;
  logic              w_load_use;
  logic              w_stall_evt;
  logic              w_flush_evt;

  // Load in EX writes a register the ID instruction reads ($zero never hazards)
  assign w_load_use = ex_mem_read & (ex_rt != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_rt)) |
                       (id_uses_rt & (id_rt == ex_rt)));

  assign mem_error = r_mem_error;

  // State and sequencing registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_pend_flush <= 1'b0;
      r_mem_error  <= 1'b0;
      r_force_go   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_pend_flush <= w_pend_flush_nxt;
      r_mem_error  <= w_mem_error_nxt;
      r_force_go   <= w_force_go_nxt;
    end
  end

  // Next-state and pipeline control; Reset forces the idle-advance values
  always_comb begin
    w_state_nxt      = r_state;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_pend_flush_nxt = r_pend_flush;
    w_mem_error_nxt  = r_mem_error;
    w_force_go_nxt   = 1'b0;
    w_freeze         = 1'b0;
    w_stall_evt      = 1'b0;
    w_flush_evt      = 1'b0;
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    ex_mem_write     = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    mem_wb_bubble    = 1'b0;
    redirect         = 1'b0;

    if (!Reset) begin
      // A timed-out access is treated as complete for one cycle
      w_freeze = mem_req & ~mem_ready & ~r_force_go;

      if (w_freeze) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
        w_stall_evt   = 1'b1;
        // Remember the taken branch; its flush is applied once unfrozen
        if (ex_branch_taken) w_pend_flush_nxt = 1'b1;
      end else if (ex_branch_taken | r_pend_flush) begin
        redirect         = 1'b1;
        if_id_flush      = 1'b1;
        id_ex_bubble     = 1'b1;
        w_flush_evt      = 1'b1;
        w_pend_flush_nxt = 1'b0;
      end else if (id_jump) begin
        redirect    = 1'b1;
        if_id_flush = 1'b1;
        w_flush_evt = 1'b1;
      end else if (w_load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        w_stall_evt  = 1'b1;
      end

      case (r_state)
        RUN: begin
          w_wait_cnt_nxt = '0;
          if (w_freeze) w_state_nxt = MEM_WAIT;
        end
        MEM_WAIT: begin
          if (r_wait_cnt != WAIT_MAX) w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
          if (!w_freeze) begin
            w_state_nxt = RUN;
          end else if (r_wait_cnt >= WAIT_LAST) begin
            w_mem_error_nxt = 1'b1;
            w_force_go_nxt  = 1'b1;
            w_state_nxt     = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Free-running wrap-around performance counters
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_evt) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_flush_evt) r_flush_count  <= r_flush_count + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  logic w_unused_evt;
  assign w_unused_evt = w_stall_evt ^ w_flush_evt;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed testbench for pipeline_hazard_sequencer.
module tb_pipeline_hazard_sequencer;

  localparam int unsigned CNT_W = 16;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble, redirect}
  localparam logic [6:0] C_NORM = 7'b1100100;
  localparam logic [6:0] C_LU   = 7'b0001100;
  localparam logic [6:0] C_FRZ  = 7'b0000010;
  localparam logic [6:0] C_BR   = 7'b1111101;
  localparam logic [6:0] C_JMP  = 7'b1110101;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic             id_jump, mem_req, mem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic             ex_mem_write, mem_wb_bubble, redirect, mem_error;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0]       w_ctl;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pipeline_hazard_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_write(ex_mem_write),
    .mem_wb_bubble(mem_wb_bubble), .redirect(redirect), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 CLK = ~CLK;

  assign w_ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                  ex_mem_write, mem_wb_bubble, redirect};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk(tag, 32'(w_ctl), 32'(exp));
  endtask

  // Expected counter value for the current build
  function automatic logic [31:0] cnt(input int unsigned v);
`ifdef PERF_COUNTERS_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    #2;
    chk_ctl("reset_ctl", C_NORM);
    chk("reset_err", 32'(mem_error), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    next_cyc();
    Reset = 1'b0;
    #1 chk_ctl("run_idle", C_NORM);

    // Load-use through rs: exactly one stall cycle
    next_cyc();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1 chk_ctl("lu_rs", C_LU);
    next_cyc(); idle();
    #1 chk_ctl("lu_after", C_NORM);
    chk("lu_stall", 32'(stall_cycles), cnt(1));

    // Load into $zero never stalls
    next_cyc();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1 chk_ctl("lu_zero", C_NORM);

    // Matching rt not read by the instruction: no stall; then read via rt
    next_cyc(); idle();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
    #1 chk_ctl("lu_rt_unused", C_NORM);
    next_cyc();
    id_uses_rt = 1'b1;
    #1 chk_ctl("lu_rt", C_LU);
    next_cyc(); idle();
    #1 chk("lu_rt_stall", 32'(stall_cycles), cnt(2));

    // Zero-wait access: no freeze
    mem_req = 1'b1; mem_ready = 1'b1;
    #1 chk_ctl("mem_zero_wait", C_NORM);

    // Three-cycle freeze then advance
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1 chk_ctl("frz3", C_FRZ);
    end
    next_cyc();
    mem_ready = 1'b1;
    #1 chk_ctl("frz3_done", C_NORM);
    next_cyc(); idle();
    #1 chk("frz3_stall", 32'(stall_cycles), cnt(5));

    // Taken branch in cycle 2 of a 4-cycle freeze
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      mem_req = 1'b1; mem_ready = 1'b0;
      ex_branch_taken = (i == 1);
      #1 chk_ctl("frz_br", C_FRZ);
    end
    next_cyc();
    mem_ready = 1'b1; ex_branch_taken = 1'b0;
    #1 chk_ctl("pend_flush", C_BR);
    next_cyc(); idle();
    #1 chk_ctl("pend_cleared", C_NORM);
    chk("pend_flush_cnt", 32'(flush_count), cnt(1));
    chk("pend_stall_cnt", 32'(stall_cycles), cnt(9));

    // Branch + jump + load-use together: branch flush only
    ex_branch_taken = 1'b1; id_jump = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1 chk_ctl("prio_branch", C_BR);
    next_cyc(); idle();
    #1 chk("prio_flush_cnt", 32'(flush_count), cnt(2));
    chk("prio_stall_cnt", 32'(stall_cycles), cnt(9));

    // Jump over a load-use: jump wins, no ID/EX bubble
    id_jump = 1'b1;
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1 chk_ctl("jump", C_JMP);
    next_cyc(); idle();
    #1 chk("jump_flush_cnt", 32'(flush_count), cnt(3));

    // Timeout: 1 RUN freeze cycle + 15 MEM_WAIT cycles, then one forced advance
    for (int i = 0; i < 16; i++) begin
      next_cyc();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1 chk_ctl("to_frz", C_FRZ);
      chk("to_err_low", 32'(mem_error), 32'd0);
    end
    next_cyc();
    #1 chk_ctl("to_release", C_NORM);
    chk("to_err_set", 32'(mem_error), 32'd1);
    next_cyc();
    #1 chk_ctl("to_refreeze", C_FRZ);
    next_cyc();
    mem_req = 1'b0;
    #1 chk_ctl("to_drop_req", C_NORM);
    chk("to_err_sticky", 32'(mem_error), 32'd1);
    chk("to_stall_cnt", 32'(stall_cycles), cnt(26));

    // Reset in the middle of MEM_WAIT with the request still pending
    next_cyc();
    mem_req = 1'b1;
    #1 chk_ctl("rst_frz_a", C_FRZ);
    next_cyc();
    #1 chk_ctl("rst_frz_b", C_FRZ);
    next_cyc();
    #1 chk("rst_pre_stall", 32'(stall_cycles), cnt(28));
    Reset = 1'b1;
    #1 chk_ctl("rst_mid_ctl", C_NORM);
    chk("rst_mid_err", 32'(mem_error), 32'd0);
    chk("rst_mid_stall", 32'(stall_cycles), 32'd0);
    chk("rst_mid_flush", 32'(flush_count), 32'd0);
    next_cyc();
    Reset = 1'b0; mem_req = 1'b0;
    #1 chk_ctl("post_rst", C_NORM);
    next_cyc();
    mem_req = 1'b1; mem_ready = 1'b0;
    #1 chk_ctl("post_rst_frz", C_FRZ);
    next_cyc(); idle();
    #1 chk("post_rst_stall", 32'(stall_cycles), cnt(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
